// File: rtl/op_word_queue.sv
// Op-word queue: bit-mask merges accepted writes into a shadow op word, then
// buffers the merged word (FIFO or latest-value) for a valid/ready consumer.
module op_word_queue #(
  parameter int              CH    = 4,
  parameter int              OP_W  = 8,
  parameter int              DEPTH = 4,
  parameter logic [OP_W-1:0] NUM   = 8'h5A,
  parameter int              MODE  = 0
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CH*OP_W-1:0]           in_op,
  input  logic [CH*OP_W-1:0]           in_mask,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CH*OP_W-1:0]           out_op,
  output logic [CH-1:0]                out_ch_nz,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [7:0]                   ovw_cnt
);

  localparam int W  = CH * OP_W;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [W-1:0]  shadow_q, shadow_d, merged;
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    ovw_q, ovw_d;
  logic          accept, pop;

  // Handshake: a transfer happens on a rising clock edge exactly when valid
  // and ready are both high; ready never depends combinationally on the
  // opposite side's valid/ready, and valid is never withdrawn by the DUT
  // except through a completed transfer or reset.
  always_comb begin
    merged    = (in_op & in_mask) | (shadow_q & ~in_mask);
    in_ready  = (MODE == 1) ? 1'b1 : (count_q != CNT_FULL);
    out_valid = (count_q != '0);
    accept    = in_valid & in_ready;
    pop       = out_valid & out_ready;
    out_op    = out_valid ? mem_q[rd_ptr_q] : shadow_q;

    shadow_d = shadow_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovw_d    = ovw_q;

    if (accept) shadow_d = merged;

    if (MODE == 0) begin
      if (accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)    rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (accept && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !accept) count_d = count_q - CNT_ONE;
    end else begin
      // Single holding slot at index 0; an accept alongside a pop is a
      // hand-over, not an overwrite, so the overwrite counter stays put.
      if (accept) begin
        count_d = CNT_ONE;
        if (!pop && (count_q != '0) && (ovw_q != 8'hFF)) ovw_d = ovw_q + 8'd1;
      end else if (pop) begin
        count_d = '0;
      end
    end
  end

  always_comb begin
    out_ch_nz = '0;
    for (int k = 0; k < CH; k++) out_ch_nz[k] = |out_op[k*OP_W +: OP_W];
  end

  assign count   = count_q;
  assign ovw_cnt = ovw_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      shadow_q <= {CH{NUM}};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovw_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovw_q    <= ovw_d;
    end
  end

  // Storage carries no reset: entries are only observed while out_valid is high.
  always_ff @(posedge clock) begin
    if (!rst && accept) mem_q[wr_ptr_q] <= merged;
  end

endmodule

// File: tb/tb_op_word_queue.sv
// Directed bench for op_word_queue: one FIFO-mode and one LATEST-mode instance.
module tb_op_word_queue;

  logic        clock = 1'b0;
  logic        rst;
  int          tests = 0;
  int          fails = 0;

  logic        f_in_valid, f_in_ready, f_out_valid, f_out_ready;
  logic [31:0] f_in_op, f_in_mask, f_out_op;
  logic [3:0]  f_ch_nz;
  logic [2:0]  f_count;
  logic [7:0]  f_ovw;

  logic        l_in_valid, l_in_ready, l_out_valid, l_out_ready;
  logic [31:0] l_in_op, l_in_mask, l_out_op;
  logic [3:0]  l_ch_nz;
  logic [2:0]  l_count;
  logic [7:0]  l_ovw;

  always #5 clock = ~clock;

  op_word_queue #(.CH(4), .OP_W(8), .DEPTH(4), .NUM(8'h5A), .MODE(0)) u_fifo (
    .clock(clock), .rst(rst),
    .in_valid(f_in_valid), .in_ready(f_in_ready), .in_op(f_in_op), .in_mask(f_in_mask),
    .out_valid(f_out_valid), .out_ready(f_out_ready), .out_op(f_out_op),
    .out_ch_nz(f_ch_nz), .count(f_count), .ovw_cnt(f_ovw)
  );

  op_word_queue #(.CH(4), .OP_W(8), .DEPTH(4), .NUM(8'h5A), .MODE(1)) u_lat (
    .clock(clock), .rst(rst),
    .in_valid(l_in_valid), .in_ready(l_in_ready), .in_op(l_in_op), .in_mask(l_in_mask),
    .out_valid(l_out_valid), .out_ready(l_out_ready), .out_op(l_out_op),
    .out_ch_nz(l_ch_nz), .count(l_count), .ovw_cnt(l_ovw)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic f_push(input logic [31:0] op, input logic [31:0] mask);
    f_in_valid = 1'b1;
    f_in_op    = op;
    f_in_mask  = mask;
    step();
    f_in_valid = 1'b0;
  endtask

  task automatic l_push(input logic [31:0] op, input logic pop);
    l_in_valid  = 1'b1;
    l_in_op     = op;
    l_in_mask   = 32'hFFFF_FFFF;
    l_out_ready = pop;
    step();
    l_in_valid  = 1'b0;
    l_out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    f_in_valid = 1'b0; f_out_ready = 1'b0; f_in_op = '0; f_in_mask = '0;
    l_in_valid = 1'b0; l_out_ready = 1'b0; l_in_op = '0; l_in_mask = '0;
    step(); step();
    rst = 1'b0;
    step();

    // Reset / idle state
    chk("rst_f_valid", 32'(f_out_valid), 32'h0);
    chk("rst_f_op", f_out_op, 32'h5A5A5A5A);
    chk("rst_f_nz", 32'(f_ch_nz), 32'hF);
    chk("rst_f_ready", 32'(f_in_ready), 32'h1);
    chk("rst_f_count", 32'(f_count), 32'h0);
    chk("rst_l_op", l_out_op, 32'h5A5A5A5A);
    chk("rst_l_ovw", 32'(l_ovw), 32'h0);

    // FIFO masked merge
    f_push(32'h11223344, 32'h000000FF);
    chk("mrg1_count", 32'(f_count), 32'h1);
    chk("mrg1_valid", 32'(f_out_valid), 32'h1);
    chk("mrg1_op", f_out_op, 32'h5A5A5A44);
    f_push(32'h00000000, 32'hFF000000);
    chk("mrg2_count", 32'(f_count), 32'h2);
    chk("mrg2_head", f_out_op, 32'h5A5A5A44);
    f_out_ready = 1'b1;
    step();
    chk("mrg_pop1_op", f_out_op, 32'h005A5A44);
    chk("mrg_pop1_nz", 32'(f_ch_nz), 32'h7);
    chk("mrg_pop1_count", 32'(f_count), 32'h1);
    step();
    chk("mrg_pop2_count", 32'(f_count), 32'h0);
    chk("mrg_pop2_valid", 32'(f_out_valid), 32'h0);
    chk("mrg_shadow", f_out_op, 32'h005A5A44);
    step();
    chk("empty_pop_count", 32'(f_count), 32'h0);
    f_out_ready = 1'b0;

    // FIFO fill to full, blocked push, then pop/push at full
    for (int i = 1; i <= 4; i++) f_push(32'hA0000000 + 32'(i), 32'hFFFFFFFF);
    chk("full_count", 32'(f_count), 32'h4);
    chk("full_ready", 32'(f_in_ready), 32'h0);
    f_push(32'hA0000005, 32'hFFFFFFFF);
    chk("full_block_count", 32'(f_count), 32'h4);
    chk("full_block_head", f_out_op, 32'hA0000001);
    f_in_valid = 1'b1; f_in_op = 32'hA0000005; f_in_mask = 32'hFFFFFFFF;
    f_out_ready = 1'b1;
    step();
    chk("full_pp_count", 32'(f_count), 32'h3);
    chk("full_pp_ready", 32'(f_in_ready), 32'h1);
    chk("full_pp_head", f_out_op, 32'hA0000002);
    step();
    chk("pp2_count", 32'(f_count), 32'h3);
    chk("pp2_head", f_out_op, 32'hA0000003);
    f_in_valid = 1'b0;
    step();
    chk("drain_head4", f_out_op, 32'hA0000004);
    step();
    chk("drain_head5", f_out_op, 32'hA0000005);
    step();
    chk("drain_count", 32'(f_count), 32'h0);
    f_out_ready = 1'b0;

    // FIFO at count=2, simultaneous push/pop (pointers wrap here)
    f_push(32'hB0000001, 32'hFFFFFFFF);
    f_push(32'hB0000002, 32'hFFFFFFFF);
    chk("c2_count", 32'(f_count), 32'h2);
    chk("c2_head", f_out_op, 32'hB0000001);
    f_in_valid = 1'b1; f_in_op = 32'hB0000003; f_out_ready = 1'b1;
    step();
    f_in_valid = 1'b0;
    chk("c2_pp_count", 32'(f_count), 32'h2);
    chk("c2_pp_head", f_out_op, 32'hB0000002);
    step();
    chk("c2_drain_head", f_out_op, 32'hB0000003);
    step();
    chk("c2_drain_shadow", f_out_op, 32'hB0000003);
    f_out_ready = 1'b0;

    // Reset with occupancy 3 and a concurrent write
    f_push(32'hC0000001, 32'hFFFFFFFF);
    f_push(32'hC0000002, 32'hFFFFFFFF);
    f_push(32'hC0000003, 32'hFFFFFFFF);
    chk("prerst_count", 32'(f_count), 32'h3);
    rst = 1'b1;
    f_in_valid = 1'b1; f_in_op = 32'h12345678;
    step();
    rst = 1'b0;
    f_in_valid = 1'b0;
    chk("rst2_count", 32'(f_count), 32'h0);
    chk("rst2_valid", 32'(f_out_valid), 32'h0);
    chk("rst2_shadow", f_out_op, 32'h5A5A5A5A);
    chk("rst2_ready", 32'(f_in_ready), 32'h1);

    // LATEST mode
    l_push(32'h0A0A0A0A, 1'b0);
    chk("lat_a_count", 32'(l_count), 32'h1);
    chk("lat_a_ovw", 32'(l_ovw), 32'h0);
    l_push(32'h0B0B0B0B, 1'b0);
    l_push(32'h000C0000, 1'b0);
    chk("lat_c_op", l_out_op, 32'h000C0000);
    chk("lat_c_nz", 32'(l_ch_nz), 32'h4);
    chk("lat_c_count", 32'(l_count), 32'h1);
    chk("lat_c_ovw", 32'(l_ovw), 32'h2);
    chk("lat_ready", 32'(l_in_ready), 32'h1);
    l_push(32'h0D0D0D0D, 1'b1);
    chk("lat_pp_count", 32'(l_count), 32'h1);
    chk("lat_pp_ovw", 32'(l_ovw), 32'h2);
    chk("lat_pp_op", l_out_op, 32'h0D0D0D0D);
    l_in_valid = 1'b1; l_in_mask = 32'hFFFFFFFF;
    for (int i = 0; i < 300; i++) begin
      l_in_op = 32'(i);
      step();
    end
    l_in_valid = 1'b0;
    chk("lat_sat_ovw", 32'(l_ovw), 32'hFF);
    chk("lat_sat_op", l_out_op, 32'h0000012B);
    l_out_ready = 1'b1;
    step();
    l_out_ready = 1'b0;
    chk("lat_pop_count", 32'(l_count), 32'h0);
    chk("lat_pop_valid", 32'(l_out_valid), 32'h0);
    chk("lat_pop_ovw", 32'(l_ovw), 32'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/op_word_queue.md
Name: op_word_queue

Overview:
- Parametrised successor to the single-struct op test block: buffers multi-channel op words instead of driving a constant op field.
- Each accepted write is bit-mask merged into a shadow op word, which is reset to the package default NUM on every channel.
- The merged word is queued (FIFO mode) or held as the latest value (LATEST mode), then handed downstream over a valid/ready handshake.
- Sits between a package-typed command source and a consumer of op fields.

Parameters:
- CH, 4, number of op channels.
- OP_W, 8, op field width per channel.
- DEPTH, 4, FIFO entries; power of two, >=2; ignored in LATEST mode.
- NUM, 8'h5A, per-channel reset/default op value, OP_W bits.
- MODE, 0, 0 = FIFO, 1 = LATEST (single entry, overwrite).

Ports:
- clock  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  write request
- in_ready  out  1  write accepted when in_valid & in_ready
- in_op  in  CH*OP_W  op word; channel k occupies bits [k*OP_W +: OP_W]
- in_mask  in  CH*OP_W  per-bit write enable (1 = take in_op bit)
- out_valid  out  1  head entry available
- out_ready  in  1  consumer pop
- out_op  out  CH*OP_W  head entry if out_valid, else shadow
- out_ch_nz  out  CH  per-channel nonzero flag of out_op
- count  out  $clog2(DEPTH+1)  occupancy (0/1 in LATEST)
- ovw_cnt  out  8  LATEST-mode overwrite counter, saturating at 255

Behaviour:
- Interface: one clock, clock; rst is synchronous and active-high.
- rst (sampled on a clock edge, overrides any concurrent handshake):
  - shadow <= {CH{NUM}}; count <= 0; ovw_cnt <= 0; read/write pointers <= 0.
  - Outputs after reset: out_valid=0, out_op={CH{NUM}}, in_ready=1.
- Merge: merged = (in_op & in_mask) | (shadow & ~in_mask).
  - On accept, shadow <= merged and merged is pushed; both are visible the next cycle.
  - in_mask = 0 pushes the unchanged shadow.
- FIFO mode (MODE=0):
  - in_ready = (count != DEPTH); fully registered occupancy, no combinational path from out_ready.
  - When full, a simultaneous pop does not admit a push that cycle.
  - out_valid = (count != 0); out_op = mem[rd_ptr], combinational read of the register array.
  - Push only: count+1. Pop only: count-1. Push and pop (count between 1 and DEPTH-1): count unchanged, both pointers advance.
  - Push into empty: out_valid rises 1 cycle after accept. No bypass; latency is 1 cycle.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- LATEST mode (MODE=1):
  - in_ready = 1 always; single holding register.
  - Accept while empty: store, count <= 1.
  - Accept while occupied without pop: overwrite, ovw_cnt += 1 (saturates at 255).
  - Accept together with pop: the old entry is consumed, the new one is stored, count stays 1, ovw_cnt unchanged.
  - Pop only: count <= 0.
- out_ch_nz[k] = |out_op[k*OP_W +: OP_W], combinational.
- No state change on in_valid without in_ready, or on out_ready without out_valid.

Test Plan:
1. Reset, then idle → out_valid=0, out_op=32'h5A5A5A5A, out_ch_nz=4'hF, in_ready=1, count=0.
2. FIFO: push in_op=32'h11223344 with mask=32'h000000FF, then push in_op=32'h0 with mask=32'hFF000000 → entries 32'h5A5A5A44 then 32'h005A5A44; out_ch_nz for entry 2 = 4'b0111.
3. FIFO: 4 pushes with out_ready=0 → count=4, in_ready=0; a 5th in_valid is not accepted. Then hold out_ready=1 and in_valid=1 together → one pop, in_ready returns to 1 next cycle, order preserved, and pointers wrap after 8 total pushes.
4. FIFO at count=2, push and pop in the same cycle → count stays 2, the popped value is the oldest entry.
5. LATEST: 3 pushes (A, B, C) with out_ready=0 → out_op=C, count=1, ovw_cnt=2. A push together with pop → count=1, ovw_cnt still 2. 300 overwrites → ovw_cnt=255.
6. Assert rst for 1 cycle with count=3 and in_valid=1 → next cycle count=0, out_valid=0, shadow back to 32'h5A5A5A5A, the concurrent write is discarded.
